trg_decoder: RTL and testbench
==============================

Name: trg_decoder

Overview:
Front-end trigger decoder between the ENC_TRG input pins and blkscam/blkcpld. It registers the 3-bit encoded trigger bus and decodes it into single-cycle LCT, L1A and L1A_MATCH strobes and a qualified RESYNC level. It also maintains a bunch-crossing counter, an L1A event counter and an illegal-code error counter for status readout. Its outputs replace the combinational decode at the top level.

Parameters:
TMR, 1, 1 = triplicate the FSM and counter registers with majority voting; 0 = single copy. Functional behaviour is identical in both cases.
RESYNC_MIN, 2, number of consecutive resync-request cycles required before RESYNC asserts (range 1..7).
BX_MAX, 3563, terminal value of the BX counter; the counter wraps to 0 after this value.

Ports:
CLK  in  1  25 ns system clock (clk25ns)
RST_B  in  1  asynchronous, active-low reset
ENC_TRG  in  3  encoded trigger bus {GLOBAL_RST,L1A,LCT}
TRG_DCD  in  1  1 = encoded decode mode; 0 = direct (bitwise) mode
CLR_CNT  in  1  synchronous clear of ERR_CNT
LCT  out  1  LCT strobe
L1A  out  1  L1A strobe
L1A_MATCH  out  1  L1A-with-match strobe
RESYNC  out  1  qualified resync level
BXN  out  12  bunch-crossing number
L1A_CNT  out  12  L1A event counter
ERR_CNT  out  8  illegal-code counter, saturating

Behaviour:
- Reset (RST_B=0, asynchronous): all outputs 0; input register 0; FSM in IDLE; all counters 0.
- Stage 1: ENC_TRG is registered on the rising edge of CLK into trg_q. This register is an IOB flop.
- Stage 2: trg_q is decoded, and all strobe outputs are registered. Latency from ENC_TRG to LCT/L1A/L1A_MATCH is 2 cycles.
- Encoded mode (TRG_DCD=1). Each code maps to {resync_req, l1a_match, l1a, lct}:
  - 0 -> 0000
  - 1 -> 0001
  - 2 -> 0011
  - 3 -> 0111
  - 4 -> 0010
  - 5 -> 0110
  - 7 -> 1000
  - 6 -> illegal: all decoded signals 0, and ERR_CNT increments.
- Direct mode (TRG_DCD=0):
  - lct = bit0
  - l1a = bit1
  - l1a_match = bit1
  - resync_req = bit2
  - No illegal codes exist in this mode.
- TRG_DCD is sampled every cycle alongside trg_q; a mode change takes effect on the next decode.
- Resync FSM, driven by resync_req. qcnt is a 3-bit counter.
  - IDLE: if req=1 and RESYNC_MIN=1, go to ACTIVE. If req=1 and RESYNC_MIN>1, go to ARM with qcnt=1.
  - ARM: if req=0, return to IDLE (the request was a glitch and is ignored). Otherwise qcnt++; when qcnt reaches RESYNC_MIN, go to ACTIVE.
  - ACTIVE: RESYNC=1. If req=0, go to IDLE and RESYNC=0 on the next cycle.
  - RESYNC is a registered FSM output. It asserts RESYNC_MIN cycles after the first request cycle reaches stage 2.
- Strobe suppression: LCT, L1A and L1A_MATCH are forced to 0 while the FSM is in ARM or ACTIVE.
- BXN:
  - Increments every cycle and wraps from BX_MAX to 0.
  - Held at 0 while RESYNC=1.
  - The first cycle after RESYNC falls, BXN=0; it increments from there.
- L1A_CNT:
  - 12-bit counter that wraps from 4095 to 0.
  - Increments on the cycle after L1A=1, so it is always 1 cycle behind the strobe.
  - Cleared to 0 while RESYNC=1.
  - If the increment and a clear occur in the same cycle, the clear wins.
- ERR_CNT:
  - Increments once per cycle in which an illegal code is decoded.
  - Saturates at 255.
  - If CLR_CNT=1 in the same cycle as an error, the clear wins and ERR_CNT=0.
  - Not affected by RESYNC.
- TMR=1: each triplicated register is voted every cycle. A single-copy upset must not be visible at any output.

Test Plan:
- Reset then idle: release RST_B and drive ENC_TRG=0 for 10 cycles -> all strobes 0, BXN counts 0..9, L1A_CNT=0, ERR_CNT=0.
- Encoded decode: TRG_DCD=1, apply codes 1,2,3,4,5 one cycle each -> 2 cycles later LCT/L1A/L1A_MATCH show 001,011,111,010,110 (as {L1A_MATCH,L1A,LCT}), and L1A_CNT ends at 4.
- Resync qualification (RESYNC_MIN=2): code 7 for 1 cycle -> RESYNC stays 0. Code 7 for 5 cycles -> RESYNC high for 4 cycles, BXN held at 0, then BXN=0,1,2 after release. An L1A code applied during the request produces no strobe.
- Illegal code: code 6 for 300 cycles -> ERR_CNT=255 (saturated). Then CLR_CNT=1 with code 6 in the same cycle -> ERR_CNT=0.
- BX wrap: run 3565 cycles after resync -> BXN goes 3563 -> 0 -> 1.
- Direct mode with async reset: TRG_DCD=0 and ENC_TRG=3'b011 -> LCT=L1A=L1A_MATCH=1. Assert RST_B=0 mid-resync -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/trg_decoder.sv
// trg_decoder
//   Front-end trigger decoder. Registers the 3-bit encoded trigger bus,
//   decodes it into LCT / L1A / L1A_MATCH strobes and a qualified RESYNC
//   level, and keeps BX, L1A-event and illegal-code counters.
//
// Ports
//   CLK        25 ns system clock (clk25ns)
//   RST_B      asynchronous active-low reset
//   ENC_TRG    encoded trigger bus {GLOBAL_RST, L1A, LCT}
//   TRG_DCD    1 = encoded decode, 0 = direct bitwise mode
//   CLR_CNT    synchronous clear of ERR_CNT
//   LCT, L1A, L1A_MATCH   single-cycle strobes, 2 cycles after ENC_TRG
//   RESYNC     qualified resync level
//   BXN        bunch-crossing number, wraps after BX_MAX
//   L1A_CNT    L1A event counter, one cycle behind the L1A strobe
//   ERR_CNT    illegal-code counter, saturating at 255
module trg_decoder #(
    parameter int TMR        = 1,
    parameter int RESYNC_MIN = 2,
    parameter int BX_MAX     = 3563
) (
    input  logic        CLK,
    input  logic        RST_B,
    input  logic [2:0]  ENC_TRG,
    input  logic        TRG_DCD,
    input  logic        CLR_CNT,
    output logic        LCT,
    output logic        L1A,
    output logic        L1A_MATCH,
    output logic        RESYNC,
    output logic [11:0] BXN,
    output logic [11:0] L1A_CNT,
    output logic [7:0]  ERR_CNT
);

    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, ACTIVE = 2'd2} state_t;

    // Everything that gets triplicated lives in one struct so the voter
    // is a single bitwise majority.
    typedef struct packed {
        state_t      state;
        logic [2:0]  qcnt;
        logic        resync;
        logic [11:0] bxn;
        logic [11:0] l1a_cnt;
        logic [7:0]  err_cnt;
    } prot_t;

    localparam int NCOPY = (TMR != 0) ? 3 : 1;

    // Stage 1: input capture (intended for the IOB flops).
    logic [2:0] trg_q;
    logic       dcd_q;

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            trg_q <= 3'b000;
            dcd_q <= 1'b0;
        end else begin
            trg_q <= ENC_TRG;
            dcd_q <= TRG_DCD;
        end
    end

    // Stage 2 decode: dec = {resync_req, l1a_match, l1a, lct}
    logic [3:0] dec;
    logic       illegal;

    always_comb begin
        dec     = 4'b0000;
        illegal = 1'b0;
        if (dcd_q) begin
            case (trg_q)
                3'd1:    dec = 4'b0001;
                3'd2:    dec = 4'b0011;
                3'd3:    dec = 4'b0111;
                3'd4:    dec = 4'b0010;
                3'd5:    dec = 4'b0110;
                3'd6:    illegal = 1'b1;
                3'd7:    dec = 4'b1000;
                default: dec = 4'b0000;
            endcase
        end else begin
            dec = {trg_q[2], trg_q[1], trg_q[1], trg_q[0]};
        end
    end

    // Protected state: NCOPY copies, all loaded from the same voted next value.
    prot_t cp [NCOPY];
    prot_t cur;
    prot_t nxt;

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            for (int i = 0; i < NCOPY; i++) cp[i] <= '0;
        end else begin
            for (int i = 0; i < NCOPY; i++) cp[i] <= nxt;
        end
    end

    generate
        if (NCOPY == 3) begin : g_vote
            assign cur = prot_t'((cp[0] & cp[1]) | (cp[0] & cp[2]) | (cp[1] & cp[2]));
        end else begin : g_single
            assign cur = cp[0];
        end
    endgenerate

    always_comb begin
        nxt = cur;
        case (cur.state)
            IDLE: begin
                if (dec[3]) begin
                    if (RESYNC_MIN == 1) begin
                        nxt.state = ACTIVE;
                    end else begin
                        nxt.state = ARM;
                        nxt.qcnt  = 3'd1;
                    end
                end
            end
            ARM: begin
                // A request shorter than RESYNC_MIN is treated as a glitch.
                if (!dec[3]) begin
                    nxt.state = IDLE;
                end else begin
                    nxt.qcnt = cur.qcnt + 3'd1;
                    if ({1'b0, cur.qcnt} + 4'd1 == 4'(RESYNC_MIN)) nxt.state = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!dec[3]) nxt.state = IDLE;
            end
            default: nxt.state = IDLE;
        endcase

        nxt.resync = (nxt.state == ACTIVE);

        // Holding on the current level as well gives BXN=0 in the first
        // cycle after RESYNC drops, so counting restarts 0,1,2...
        if (nxt.resync || cur.resync)
            nxt.bxn = 12'd0;
        else if (cur.bxn == 12'(BX_MAX))
            nxt.bxn = 12'd0;
        else
            nxt.bxn = cur.bxn + 12'd1;

        // Counts the registered L1A strobe, hence one cycle behind it.
        if (nxt.resync)
            nxt.l1a_cnt = 12'd0;
        else
            nxt.l1a_cnt = cur.l1a_cnt + {11'd0, L1A};

        if (CLR_CNT)
            nxt.err_cnt = 8'd0;
        else if (illegal && cur.err_cnt != 8'hFF)
            nxt.err_cnt = cur.err_cnt + 8'd1;
    end

    // Strobes are blanked whenever a resync request is being qualified or active.
    logic strobe_ok;
    assign strobe_ok = (cur.state == IDLE);

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            LCT       <= 1'b0;
            L1A       <= 1'b0;
            L1A_MATCH <= 1'b0;
        end else begin
            LCT       <= dec[0] & strobe_ok;
            L1A       <= dec[1] & strobe_ok;
            L1A_MATCH <= dec[2] & strobe_ok;
        end
    end

    assign RESYNC  = cur.resync;
    assign BXN     = cur.bxn;
    assign L1A_CNT = cur.l1a_cnt;
    assign ERR_CNT = cur.err_cnt;

endmodule

// File: tb/tb_trg_decoder.sv
// tb_trg_decoder
//   Directed stimulus for trg_decoder, with a cycle-level reference model
//   built from the decode table, request run lengths and cycle arithmetic,
//   compared against the DUT on every falling clock edge.
module tb_trg_decoder;

    localparam int RESYNC_MIN = 2;
    localparam int BX_MAX     = 3563;

    logic        CLK     = 1'b0;
    logic        RST_B   = 1'b0;
    logic [2:0]  ENC_TRG = 3'd0;
    logic        TRG_DCD = 1'b0;
    logic        CLR_CNT = 1'b0;
    logic        LCT, L1A, L1A_MATCH, RESYNC;
    logic [11:0] BXN, L1A_CNT;
    logic [7:0]  ERR_CNT;

    int n_total = 0;
    int n_bad   = 0;

    trg_decoder #(.TMR(1), .RESYNC_MIN(RESYNC_MIN), .BX_MAX(BX_MAX)) dut (
        .CLK(CLK), .RST_B(RST_B), .ENC_TRG(ENC_TRG), .TRG_DCD(TRG_DCD),
        .CLR_CNT(CLR_CNT), .LCT(LCT), .L1A(L1A), .L1A_MATCH(L1A_MATCH),
        .RESYNC(RESYNC), .BXN(BXN), .L1A_CNT(L1A_CNT), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // returns {illegal, resync_req, l1a_match, l1a, lct}
    function automatic logic [4:0] spec_decode(input logic [2:0] c, input logic dcd);
        logic [3:0] tab [8];
        tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b0010, 4'b0110, 4'b0000, 4'b1000};
        if (!dcd) return {1'b0, c[2], c[1], c[1], c[0]};
        if (c == 3'd6) return 5'b10000;
        return {1'b0, tab[c]};
    endfunction

    logic [2:0] m_trg   = 3'd0;
    logic       m_dcd   = 1'b0;
    int         run     = 0;      // consecutive decoded request cycles
    bit         e_lct   = 0, e_l1a = 0, e_match = 0, e_res = 0;
    int         e_bxn   = 0, e_l1a_cnt = 0, e_err = 0;
    longint     cyc     = 0, origin = 0;

    task automatic model_reset();
        m_trg = 3'd0; m_dcd = 1'b0; run = 0;
        e_lct = 0; e_l1a = 0; e_match = 0; e_res = 0;
        e_bxn = 0; e_l1a_cnt = 0; e_err = 0; cyc = 0; origin = 0;
    endtask

    task automatic model_step();
        logic [4:0] d;
        int prev_run;
        bit prev_l1a;
        d        = spec_decode(m_trg, m_dcd);
        prev_run = run;
        prev_l1a = e_l1a;
        run      = d[3] ? ((run < 100) ? run + 1 : run) : 0;
        e_res    = (run >= RESYNC_MIN);
        e_lct    = d[0] && prev_run == 0;
        e_l1a    = d[1] && prev_run == 0;
        e_match  = d[2] && prev_run == 0;
        if (e_res)         e_l1a_cnt = 0;
        else if (prev_l1a) e_l1a_cnt = (e_l1a_cnt + 1) % 4096;
        if (CLR_CNT)                e_err = 0;
        else if (d[4] && e_err < 255) e_err = e_err + 1;
        cyc++;
        // BXN = cycles since reset or since the last RESYNC-high cycle, mod period
        if (e_res) begin
            e_bxn  = 0;
            origin = cyc + 1;
        end else begin
            e_bxn = int'((cyc - origin) % (BX_MAX + 1));
        end
        m_trg = ENC_TRG;
        m_dcd = TRG_DCD;
    endtask

    initial forever begin
        @(posedge CLK or negedge RST_B);
        if (!RST_B) model_reset();
        else        model_step();
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge CLK);
        chk("cyc_LCT",       LCT,       e_lct);
        chk("cyc_L1A",       L1A,       e_l1a);
        chk("cyc_L1A_MATCH", L1A_MATCH, e_match);
        chk("cyc_RESYNC",    RESYNC,    e_res);
        chk("cyc_BXN",       BXN,       e_bxn);
        chk("cyc_L1A_CNT",   L1A_CNT,   e_l1a_cnt);
        chk("cyc_ERR_CNT",   ERR_CNT,   e_err);
    end

    // ---------------- directed sequence ----------------
    int         codes   [8] = '{1, 2, 3, 4, 5, 0, 0, 0};
    logic [2:0] exp_obs [5] = '{3'b001, 3'b011, 3'b111, 3'b010, 3'b110};
    logic [2:0] obs     [8];
    bit         rs      [20];
    int         bx      [20];

    initial begin
        bit saw_res, saw_l1a, seen;
        int highs, fall;

        repeat (3) @(negedge CLK);
        chk("rst_BXN", BXN, 0);
        chk("rst_strobes", {L1A_MATCH, L1A, LCT, RESYNC}, 0);
        RST_B = 1'b1;

        // idle counting
        repeat (9) @(negedge CLK);
        chk("idle_BXN9", BXN, 9);
        chk("idle_L1A_CNT", L1A_CNT, 0);
        chk("idle_ERR_CNT", ERR_CNT, 0);

        // encoded decode, strobe visible two cycles after the code
        TRG_DCD = 1'b1;
        for (int j = 0; j < 8; j++) begin
            obs[j]  = {L1A_MATCH, L1A, LCT};
            ENC_TRG = 3'(codes[j]);
            @(negedge CLK);
        end
        for (int j = 0; j < 5; j++) chk($sformatf("enc_code%0d", j + 1), obs[j + 2], exp_obs[j]);
        chk("enc_L1A_CNT4", L1A_CNT, 4);

        // one-cycle request followed by an L1A code: ignored and suppressed
        ENC_TRG = 3'd7; @(negedge CLK);
        ENC_TRG = 3'd3; @(negedge CLK);
        ENC_TRG = 3'd0;
        saw_res = 0; saw_l1a = 0;
        repeat (6) begin
            @(negedge CLK);
            saw_res |= RESYNC;
            saw_l1a |= L1A;
        end
        chk("glitch_RESYNC", saw_res, 0);
        chk("glitch_L1A_suppressed", saw_l1a, 0);
        chk("glitch_L1A_CNT", L1A_CNT, 4);

        // five-cycle request: RESYNC high for 4 cycles, BXN restarts 0,1,2
        for (int i = 0; i < 20; i++) begin
            rs[i]   = RESYNC;
            bx[i]   = BXN;
            ENC_TRG = (i < 5) ? 3'd7 : 3'd0;
            @(negedge CLK);
        end
        highs = 0; fall = -1;
        for (int i = 0; i < 20; i++) begin
            if (rs[i]) highs++;
            if (i > 0 && fall < 0 && rs[i - 1] && !rs[i]) fall = i;
        end
        chk("resync_high_cycles", highs, 4);
        chk("resync_fall_index", fall, 7);
        if (fall >= 0 && fall <= 17) begin
            chk("resync_bx0", bx[fall], 0);
            chk("resync_bx1", bx[fall + 1], 1);
            chk("resync_bx2", bx[fall + 2], 2);
        end
        chk("resync_L1A_CNT", L1A_CNT, 0);

        // illegal code saturation and clear-wins
        ENC_TRG = 3'd6;
        repeat (300) @(negedge CLK);
        chk("err_sat", ERR_CNT, 255);
        CLR_CNT = 1'b1; @(negedge CLK);
        CLR_CNT = 1'b0;
        chk("err_clr", ERR_CNT, 0);
        ENC_TRG = 3'd0;
        repeat (3) @(negedge CLK);
        chk("err_after_clr", ERR_CNT, 1);

        // BX wrap after a resync
        ENC_TRG = 3'd7; repeat (3) @(negedge CLK);
        ENC_TRG = 3'd0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge CLK); if (RESYNC) seen = 1; end
        chk("bxwrap_rise_wait", seen, 1);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge CLK); if (!RESYNC) seen = 1; end
        chk("bxwrap_fall_wait", seen, 1);
        chk("bxwrap_start", BXN, 0);
        repeat (3563) @(negedge CLK);
        chk("bxwrap_max", BXN, 3563);
        @(negedge CLK); chk("bxwrap_zero", BXN, 0);
        @(negedge CLK); chk("bxwrap_one", BXN, 1);

        // direct mode, then asynchronous reset in the middle of a resync
        TRG_DCD = 1'b0; ENC_TRG = 3'b011;
        repeat (2) @(negedge CLK);
        chk("direct_strobes", {L1A_MATCH, L1A, LCT}, 3'b111);
        ENC_TRG = 3'b100;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin @(negedge CLK); if (RESYNC) seen = 1; end
        chk("direct_resync_wait", seen, 1);
        #3 RST_B = 1'b0;
        #1;
        chk("async_rst_strobes", {L1A_MATCH, L1A, LCT, RESYNC}, 0);
        chk("async_rst_BXN", BXN, 0);
        chk("async_rst_L1A_CNT", L1A_CNT, 0);
        chk("async_rst_ERR_CNT", ERR_CNT, 0);
        ENC_TRG = 3'd0;
        @(negedge CLK);
        RST_B = 1'b1;
        repeat (3) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
